// File: rtl/btn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_pkg: shared FSM encoding, event codes and counter sizing.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package btn_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESS_DEB = 3'd1;
  localparam logic [2:0] HELD      = 3'd2;
  localparam logic [2:0] LONG_HELD = 3'd3;
  localparam logic [2:0] REL_DEB   = 3'd4;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] SHORT = 2'd1;
  localparam logic [1:0] LONG  = 2'd2;

  // Bits needed to hold 0..max_val inclusive, never narrower than one bit.
  function automatic int cnt_width(input longint unsigned max_val);
    int w;
    w = $clog2(max_val + 64'd1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_channel: synchronise, debounce, time and stretch one button.    |
// | Optional macro BTN_AUTO_REPEAT_EN: re-fire long event while held.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned PULSE_CYCLES    = 100_000_000
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 50_000_000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev_short,
  output logic ev_long
);

  // Debounce counting starts at 1 on the first qualifying sample, so
  // DEBOUNCE_CYCLES is expected to be at least 2.
  localparam int c_deb_w = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);

  localparam int c_dur_w = cnt_width(LONG_CYCLES);
  localparam logic [c_dur_w-1:0] c_dur_one   = c_dur_w'(1);
  localparam logic [c_dur_w-1:0] c_dur_max   = c_dur_w'(LONG_CYCLES);
  localparam logic [c_dur_w-1:0] c_long_last = c_dur_w'(LONG_CYCLES - 1);

  localparam int c_pls_w = cnt_width(PULSE_CYCLES);
  localparam logic [c_pls_w-1:0] c_pls_one  = c_pls_w'(1);
  localparam logic [c_pls_w-1:0] c_pls_load = c_pls_w'(PULSE_CYCLES);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int c_rep_w = cnt_width(REPEAT_CYCLES);
  localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);
  localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);

  logic [c_rep_w-1:0] r_rep_cnt;
  logic               w_rep_hit;
`endif

  logic               r_sync1;
  logic               r_sync2;
  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic [c_dur_w-1:0] r_dur_cnt;
  logic               r_short_flag;
  logic [1:0]         w_evt;
  logic [1:0]         r_evt;
  logic [c_pls_w-1:0] r_pulse_cnt;
  logic               r_short_q;
  logic               r_long_q;
  logic               w_deb_done;
  logic               w_long_hit;

  assign w_deb_done = (r_deb_cnt >= c_deb_last);
  assign w_long_hit = (r_dur_cnt >= c_long_last);
`ifdef BTN_AUTO_REPEAT_EN
  assign w_rep_hit  = (r_rep_cnt >= c_rep_last);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (r_sync2) w_state_next = PRESS_DEB;
      PRESS_DEB: begin
        if (!r_sync2)        w_state_next = IDLE;
        else if (w_deb_done) w_state_next = HELD;
      end
      HELD: begin
        if (!r_sync2)        w_state_next = REL_DEB;
        else if (w_long_hit) w_state_next = LONG_HELD;
      end
      LONG_HELD: if (!r_sync2) w_state_next = REL_DEB;
      REL_DEB: begin
        if (r_sync2)         w_state_next = r_short_flag ? HELD : LONG_HELD;
        else if (w_deb_done) w_state_next = IDLE;
      end
      default:               w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_evt = NONE;
    case (r_state)
      HELD:      if (r_sync2 && w_long_hit) w_evt = LONG;
`ifdef BTN_AUTO_REPEAT_EN
      LONG_HELD: if (r_sync2 && w_rep_hit) w_evt = LONG;
`endif
      REL_DEB:   if (!r_sync2 && w_deb_done && r_short_flag) w_evt = SHORT;
      default:   w_evt = NONE;
    endcase
  end

  // Debounce, duration and (optional) repeat counters follow the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb_cnt    <= '0;
      r_dur_cnt    <= '0;
      r_short_flag <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_rep_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_deb_cnt <= r_sync2 ? c_deb_one : '0;
          r_dur_cnt <= '0;
`ifdef BTN_AUTO_REPEAT_EN
          r_rep_cnt <= '0;
`endif
        end
        PRESS_DEB: begin
          if (!r_sync2 || w_deb_done) r_deb_cnt <= '0;
          else                        r_deb_cnt <= r_deb_cnt + c_deb_one;
          if (r_sync2 && w_deb_done)  r_dur_cnt <= '0;
        end
        HELD: begin
          if (!r_sync2) begin
            r_deb_cnt    <= c_deb_one;
            r_short_flag <= 1'b1;
          end else begin
            if (r_dur_cnt != c_dur_max) r_dur_cnt <= r_dur_cnt + c_dur_one;
`ifdef BTN_AUTO_REPEAT_EN
            if (w_long_hit) r_rep_cnt <= '0;
`endif
          end
        end
        LONG_HELD: begin
          if (!r_sync2) begin
            r_deb_cnt    <= c_deb_one;
            r_short_flag <= 1'b0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (w_rep_hit) r_rep_cnt <= '0;
          else                r_rep_cnt <= r_rep_cnt + c_rep_one;
`endif
        end
        REL_DEB: begin
          if (r_sync2 || w_deb_done) r_deb_cnt <= '0;
          else                       r_deb_cnt <= r_deb_cnt + c_deb_one;
        end
        default: r_deb_cnt <= '0;
      endcase
    end
  end

  // A new event reloads the stretch and replaces the previous event type.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_evt       <= NONE;
      r_pulse_cnt <= '0;
      r_short_q   <= 1'b0;
      r_long_q    <= 1'b0;
    end else begin
      r_evt <= w_evt;
      if (r_evt != NONE) begin
        r_pulse_cnt <= c_pls_load;
        r_short_q   <= (r_evt == SHORT);
        r_long_q    <= (r_evt == LONG);
      end else if (r_pulse_cnt != '0) begin
        r_pulse_cnt <= r_pulse_cnt - c_pls_one;
        if (r_pulse_cnt == c_pls_one) begin
          r_short_q <= 1'b0;
          r_long_q  <= 1'b0;
        end
      end
    end
  end

  assign ev_short = r_short_q;
  assign ev_long  = r_long_q;

endmodule
`default_nettype wire

// File: rtl/button_press_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | button_press_classifier: two independent short/long press channels.|
// | Optional macro BTN_AUTO_REPEAT_EN: auto-repeat of the long event.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned PULSE_CYCLES    = 100_000_000
`ifdef BTN_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES   = 50_000_000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn0,
  input  logic btn1,
  output logic b0short,
  output logic b0long,
  output logic b1short,
  output logic b1long
);

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .PULSE_CYCLES   (PULSE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
  ) u_ch0 (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn0),
    .ev_short(b0short),
    .ev_long (b0long)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .PULSE_CYCLES   (PULSE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
  ) u_ch1 (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn1),
    .ev_short(b1short),
    .ev_long (b1long)
  );

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_button_press_classifier: table vectors, corner sequences and     |
// | random presses against a press-level model. Rev 1.0                 |
// +--------------------------------------------------------------------+
module tb_button_press_classifier;

  localparam int D      = 4;
  localparam int L      = 20;
  localparam int P      = 3;
  localparam int R      = 8;
  localparam int MAXN   = 3000;
  localparam int SHORT_T = 1;
  localparam int LONG_T  = 2;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int N40 = 3;
  localparam int N50 = 4;
`else
  localparam int N40 = 1;
  localparam int N50 = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn0 = 1'b0;
  logic btn1 = 1'b0;
  logic b0short, b0long, b1short, b1long;

  int n_checks = 0;
  int n_fail   = 0;

  bit raw   [0:1][0:MAXN-1];
  bit exp_s [0:1][0:MAXN-1];
  bit exp_l [0:1][0:MAXN-1];
  int first_s [0:1];
  int first_l [0:1];
  int n_rise  [0:1];
  int n_high  [0:1];
  int n_both  [0:1];

  typedef struct {
    int h0; int h1;
    int s0; int l0; int n0;
    int s1; int l1; int n1;
  } vec_t;
  vec_t vecs [0:6];

  button_press_classifier #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .PULSE_CYCLES   (P)
`ifdef BTN_AUTO_REPEAT_EN
    ,
    .REPEAT_CYCLES  (R)
`endif
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn0   (btn0),
    .btn1   (btn1),
    .b0short(b0short),
    .b0long (b0long),
    .b1short(b1short),
    .b1long (b1long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int t, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s (t=%0d): got %0d, expected %0d", name, t, act, expv);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    btn0 = 1'b0;
    btn1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_raw();
    for (int ch = 0; ch < 2; ch++)
      for (int t = 0; t < MAXN; t++) raw[ch][t] = 1'b0;
  endtask

  // Output is high for P cycles from te; a later event overwrites the tail.
  task automatic add_evt(input int ch, input int te, input int ty, input int n);
    for (int k = 0; k < P; k++)
      if (te + k < n) begin
        exp_s[ch][te+k] = (ty == SHORT_T);
        exp_l[ch][te+k] = (ty == LONG_T);
      end
  endtask

  // Each run of h high input cycles starting at s (sampled at edge s) is one
  // press: accepted after D samples, long once h-D reaches L, else short
  // after the release debounce. Events appear 2 sync + 1 register cycles on.
  task automatic build_model(input int n);
    int h;
    for (int ch = 0; ch < 2; ch++) begin
      for (int t = 0; t < n; t++) begin
        exp_s[ch][t] = 1'b0;
        exp_l[ch][t] = 1'b0;
      end
      for (int s = 0; s < n; s++) begin
        if (raw[ch][s] && (s == 0 || !raw[ch][s-1])) begin
          h = 0;
          while (s + h < n && raw[ch][s+h]) h++;
          if (h >= D) begin
            if (h - D >= L) begin
              add_evt(ch, s + 2 + D + L, LONG_T, n);
`ifdef BTN_AUTO_REPEAT_EN
              for (int k = 1; h - D >= L + k * R; k++)
                add_evt(ch, s + 2 + D + L + k * R, LONG_T, n);
`endif
            end else begin
              add_evt(ch, s + h + 2 + D, SHORT_T, n);
            end
          end
        end
      end
    end
  endtask

  // Call at a negedge with rst released; raw[*][t] is sampled at edge t.
  task automatic run_window(input int n, input string tag);
    bit o    [0:1][0:1];
    bit prev [0:1][0:1];
    build_model(n);
    for (int ch = 0; ch < 2; ch++) begin
      first_s[ch] = -1; first_l[ch] = -1;
      n_rise[ch] = 0; n_high[ch] = 0; n_both[ch] = 0;
      prev[ch][0] = 1'b0; prev[ch][1] = 1'b0;
    end
    for (int t = 0; t < n; t++) begin
      btn0 = raw[0][t];
      btn1 = raw[1][t];
      @(posedge clk);
      @(negedge clk);
      o[0][0] = b0short; o[0][1] = b0long;
      o[1][0] = b1short; o[1][1] = b1long;
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("%s b%0dshort", tag, ch), t, int'(o[ch][0]), int'(exp_s[ch][t]));
        check($sformatf("%s b%0dlong", tag, ch), t, int'(o[ch][1]), int'(exp_l[ch][t]));
        if (o[ch][0] && !prev[ch][0]) begin
          n_rise[ch]++;
          if (first_s[ch] < 0) first_s[ch] = t;
        end
        if (o[ch][1] && !prev[ch][1]) begin
          n_rise[ch]++;
          if (first_l[ch] < 0) first_l[ch] = t;
        end
        n_high[ch] += int'(o[ch][0]) + int'(o[ch][1]);
        if (o[ch][0] && o[ch][1]) n_both[ch]++;
        prev[ch][0] = o[ch][0];
        prev[ch][1] = o[ch][1];
      end
    end
  endtask

  task automatic gen_random(input int n);
    int t, h, gap, kind;
    clear_raw();
    for (int ch = 0; ch < 2; ch++) begin
      t = 3;
      while (t < n - 60) begin
        kind = int'($urandom_range(0, 3));
        gap  = int'($urandom_range(D, D + 6));
        case (kind)
          0: begin
            h   = int'($urandom_range(1, D - 1));
            gap = int'($urandom_range(1, 3));
          end
          1:       h = int'($urandom_range(D, D + L - 1));
          2:       h = int'($urandom_range(D + L - 2, D + L + 2));
          default: h = int'($urandom_range(D + L, D + L + 3 * R));
        endcase
        if (t + h + gap > n - 60) break;
        for (int k = 0; k < h; k++) raw[ch][t+k] = 1'b1;
        t += h + gap;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            h0  h1  s0  l0  n0   s1  l1  n1
    vecs[0] = '{14,  0, 20, -1,  1,  -1, -1,   0};  // clean short
    vecs[1] = '{ 0, 40, -1, -1,  0,  -1, 26, N40};  // long hold
    vecs[2] = '{ 3,  2, -1, -1,  0,  -1, -1,   0};  // below debounce
    vecs[3] = '{ 4, 23, 10, -1,  1,  29, -1,   1};  // debounce edge, L-1
    vecs[4] = '{24, 14, -1, 26,  1,  20, -1,   1};  // exactly long
    vecs[5] = '{14, 14, 20, -1,  1,  20, -1,   1};  // simultaneous
    vecs[6] = '{ 0, 50, -1, -1,  0,  -1, 26, N50};  // repeat window

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset b0short", 0, int'(b0short), 0);
    check("reset b0long",  0, int'(b0long),  0);
    check("reset b1short", 0, int'(b1short), 0);
    check("reset b1long",  0, int'(b1long),  0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      clear_raw();
      for (int t = 0; t < vecs[i].h0; t++) raw[0][t] = 1'b1;
      for (int t = 0; t < vecs[i].h1; t++) raw[1][t] = 1'b1;
      run_window(70, $sformatf("vec%0d", i));
      check($sformatf("vec%0d b0short_rise", i), 0, first_s[0], vecs[i].s0);
      check($sformatf("vec%0d b0long_rise", i),  0, first_l[0], vecs[i].l0);
      check($sformatf("vec%0d b0_pulses", i),    0, n_rise[0],  vecs[i].n0);
      check($sformatf("vec%0d b0_high", i),      0, n_high[0],  vecs[i].n0 * P);
      check($sformatf("vec%0d b0_overlap", i),   0, n_both[0],  0);
      check($sformatf("vec%0d b1short_rise", i), 0, first_s[1], vecs[i].s1);
      check($sformatf("vec%0d b1long_rise", i),  0, first_l[1], vecs[i].l1);
      check($sformatf("vec%0d b1_pulses", i),    0, n_rise[1],  vecs[i].n1);
      check($sformatf("vec%0d b1_high", i),      0, n_high[1],  vecs[i].n1 * P);
      check($sformatf("vec%0d b1_overlap", i),   0, n_both[1],  0);
    end

    // Glitches then a stable press on btn0; glitches only on btn1
    do_reset();
    clear_raw();
    raw[0][2] = 1'b1;
    raw[0][4] = 1'b1; raw[0][5] = 1'b1;
    raw[0][7] = 1'b1; raw[0][8] = 1'b1; raw[0][9] = 1'b1;
    for (int t = 11; t < 21; t++) raw[0][t] = 1'b1;
    raw[1][3] = 1'b1;
    raw[1][6] = 1'b1; raw[1][7] = 1'b1;
    raw[1][10] = 1'b1; raw[1][11] = 1'b1; raw[1][12] = 1'b1;
    run_window(60, "glitch");
    check("glitch b0short_rise", 0, first_s[0], 27);
    check("glitch b0_pulses",    0, n_rise[0],  1);
    check("glitch b0long_rise",  0, first_l[0], -1);
    check("glitch b1_pulses",    0, n_rise[1],  0);

    // Asynchronous reset in the middle of a held press
    do_reset();
    for (int t = 0; t < 28; t++) begin
      btn0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("prereset b0long", 27, int'(b0long), 1);
    #2 rst = 1'b0;
    #1;
    check("async rst b0short", 0, int'(b0short), 0);
    check("async rst b0long",  0, int'(b0long),  0);
    check("async rst b1short", 0, int'(b1short), 0);
    check("async rst b1long",  0, int'(b1long),  0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_raw();
    for (int t = 0; t < 10; t++) raw[0][t] = 1'b1;
    run_window(40, "postrst");
    check("postrst b0short_rise", 0, first_s[0], 16);
    check("postrst b0long_rise",  0, first_l[0], -1);
    check("postrst b0_pulses",    0, n_rise[0],  1);

    // Random press/glitch traffic on both channels
    do_reset();
    gen_random(MAXN);
    run_window(MAXN, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
